key_conditioner: RTL and testbench

- Upstream conditioning stage for the ticket-counter/display logic. Takes one raw active-low push-button.
- Synchronises the button into clk and debounces press and release.
- Emits single-cycle press, release and auto-repeat strobes plus a clean level.
- Downstream counter logic consumes step/press_pulse instead of running its own hold timer.

---
 rtl/key_conditioner.sv | 72 +++++++
 tb/tb_key_conditioner.sv | 111 +++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises, debounces and auto-repeats one active-low push-button,
// emitting registered press/release/repeat strobes, a combined step strobe and a clean level.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic step
);
    typedef enum logic [2:0] {IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB} state_t;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    state_t state, nstate;
    logic [CNT_W-1:0] cnt, ncnt;
    logic sync0, key_s;
    logic press_d, release_d, repeat_d, level_d;
    logic wrap, hold;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            sync0         <= 1'b0;
            key_s         <= 1'b0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            step          <= 1'b0;
        end else begin
            sync0         <= ~key_n;
            key_s         <= sync0;
            state         <= nstate;
            cnt           <= ncnt;
            key_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            repeat_pulse  <= repeat_d;
            step          <= press_d | repeat_d;
        end
    end
    // key_s is tested before the terminal count so a release always wins
    always_comb begin
        nstate = state;
        case (state)
            IDLE:       nstate = key_s ? PRESS_DB : IDLE;
            PRESS_DB:   nstate = !key_s ? IDLE : (cnt == DB_LAST ? HELD : PRESS_DB);
            HELD:       nstate = !key_s ? RELEASE_DB : (REPEAT_EN && cnt == DLY_LAST ? REPEAT : HELD);
            REPEAT:     nstate = !key_s ? RELEASE_DB : REPEAT;
            RELEASE_DB: nstate = key_s ? HELD : (cnt == DB_LAST ? IDLE : RELEASE_DB);
            default:    nstate = IDLE;
        endcase
        wrap = state == REPEAT && cnt == PER_LAST;
        hold = state == HELD && cnt == DLY_LAST;
        ncnt = (nstate != state || wrap || state == IDLE) ? '0 : hold ? cnt : cnt + CNT_W'(1);
    end
    always_comb begin
        press_d   = state == PRESS_DB && nstate == HELD;
        release_d = state == RELEASE_DB && nstate == IDLE;
        repeat_d  = (state == HELD && nstate == REPEAT) || (wrap && key_s);
        level_d   = nstate inside {HELD, REPEAT, RELEASE_DB};
    end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed, cycle-exact checks of key_conditioner with short timing
// parameters; a second instance with auto-repeat disabled shares the same stimulus.
module tb_key_conditioner;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic key_n = 1'b1;
    logic lvl, prs, rel, rep, stp;
    logic lvl1, prs1, rel1, rep1, stp1;
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int nrep = 0;

    always #5 clk = ~clk;

    key_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
                      .REPEAT_EN(1'b1), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .key_level(lvl),
        .press_pulse(prs), .release_pulse(rel), .repeat_pulse(rep), .step(stp));

    key_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
                      .REPEAT_EN(1'b0), .CNT_W(8)) dut_norep (
        .clk(clk), .reset(reset), .key_n(key_n), .key_level(lvl1),
        .press_pulse(prs1), .release_pulse(rel1), .repeat_pulse(rep1), .step(stp1));

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_main(input string tag, input logic p, input logic r, input logic rl, input logic lv);
        check({tag, ".press"}, prs, p);
        check({tag, ".repeat"}, rep, r);
        check({tag, ".release"}, rel, rl);
        check({tag, ".level"}, lvl, lv);
        check({tag, ".step"}, stp, p | r);
    endtask

    task automatic expect_norep(input string tag, input logic p, input logic rl, input logic lv);
        check({tag, ".press1"}, prs1, p);
        check({tag, ".repeat1"}, rep1, 1'b0);
        check({tag, ".release1"}, rel1, rl);
        check({tag, ".level1"}, lvl1, lv);
        check({tag, ".step1"}, stp1, p);
    endtask

    initial begin
        // reset held, then idle with the key released
        repeat (2) tick();
        expect_main("reset", 0, 0, 0, 0);
        expect_norep("reset", 0, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_main("idle", 0, 0, 0, 0);
        end
        // clean press, then hold: press at edge 7, repeats at 17,20,...,44
        key_n = 1'b0;
        for (int k = 1; k <= 44; k++) begin
            tick();
            expect_main("press_hold", k == 7, k >= 17 && (k - 17) % 3 == 0, 0, k >= 7);
            if (rep) nrep++;
        end
        check("repeat_count", nrep == 10, 1'b1);
        // release with bounce; edge 3 coincides with the repeat terminal count
        for (int j = 1; j <= 12; j++) begin
            key_n = (j == 3) ? 1'b0 : 1'b1;
            tick();
            expect_main("release_bounce", 0, 0, j == 10, j < 10);
        end
        // press bounce: low 3, high 1, then low held; press at edge 11, repeat at 21
        for (int j = 1; j <= 22; j++) begin
            key_n = (j == 4) ? 1'b1 : 1'b0;
            tick();
            expect_main("press_bounce", j == 11, j == 21, 0, j >= 11);
        end
        // reset pulse while in REPEAT with the key still low
        reset = 1'b0;
        tick();
        expect_main("mid_reset", 0, 0, 0, 0);
        expect_norep("mid_reset", 0, 0, 0);
        reset = 1'b1;
        for (int m = 1; m <= 7; m++) begin
            tick();
            expect_main("after_reset", m == 7, 0, 0, m >= 7);
            expect_norep("after_reset", m == 7, 0, m >= 7);
        end
        // auto-repeat disabled: 50 held edges produce nothing new
        for (int m = 1; m <= 50; m++) begin
            tick();
            expect_norep("norep_hold", 0, 0, 1);
        end
        // clean release still works with repeat disabled
        key_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            expect_norep("norep_release", 0, e == 7, e < 7);
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
